branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch direction predictor: a table of saturating counters indexed by PC (bimodal) or by PC
// XOR global history (gshare), with one FD->X pipeline stage and resolution statistics.
module branch_predictor #(
    parameter int unsigned LINES     = 32,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned HIST_BITS = 5,
    parameter int unsigned MODE      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bp_enable,
    input  logic [31:0] pc_guess,
    input  logic        is_br_guess,
    input  logic        stall,
    input  logic        is_br_check,
    input  logic        br_taken,
    output logic        pred_taken,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned IDX = $clog2(LINES);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam bit PRED_ON = (MODE != 0);
    localparam bit GSHARE  = (MODE == 2);

    if (LINES < 2 || (LINES & (LINES - 1)) != 0) begin : g_bad_lines
        $error("branch_predictor: LINES must be a power of two >= 2");
    end
    if (CNT_BITS < 1) begin : g_bad_cnt
        $error("branch_predictor: CNT_BITS must be >= 1");
    end
    if (HIST_BITS < 1 || HIST_BITS > IDX) begin : g_bad_hist
        $error("branch_predictor: HIST_BITS must be in 1..log2(LINES)");
    end
    if (MODE > 2) begin : g_bad_mode
        $error("branch_predictor: MODE must be 0, 1 or 2");
    end

    logic [CNT_BITS-1:0]  cnt_table [LINES];
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [IDX-1:0]       idx_g, idx_x_q, hist_ext;
    logic                 pred_x_q;
    logic [31:0]          br_count_q, mispred_count_q;
    logic                 resolve, update;
    logic [CNT_BITS-1:0]  cnt_cur, cnt_next;
    logic                 unused_pc;

    assign unused_pc = ^{pc_guess[31:IDX+2], pc_guess[1:0]};

    // Word-aligned PC bits select the entry; gshare folds history into the low bits.
    always_comb begin
        hist_ext = '0;
        hist_ext[HIST_BITS-1:0] = ghr_q;
        idx_g = pc_guess[IDX+1:2];
        if (GSHARE) begin
            idx_g = idx_g ^ hist_ext;
        end
    end

    // Read is from the registered table, so a same-cycle update to this index is not seen.
    assign pred_taken = bp_enable & is_br_guess & PRED_ON & cnt_table[idx_g][CNT_BITS-1];

    assign resolve    = bp_enable & is_br_check;
    assign update     = resolve & PRED_ON;
    assign mispredict = resolve & (pred_x_q != br_taken);

    always_comb begin
        cnt_cur  = cnt_table[idx_x_q];
        cnt_next = cnt_cur;
        if (br_taken) begin
            if (cnt_cur != CNT_MAX) begin
                cnt_next = cnt_cur + CNT_BITS'(1);
            end
        end else begin
            if (cnt_cur != '0) begin
                cnt_next = cnt_cur - CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (update && GSHARE) begin
            ghr_d = (ghr_q << 1) | HIST_BITS'(br_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                cnt_table[i] <= CNT_INIT;
            end
        end else if (update) begin
            cnt_table[idx_x_q] <= cnt_next;
        end
    end

    // The FD->X register advances even with the predictor disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_x_q  <= '0;
            pred_x_q <= 1'b0;
        end else if (!stall) begin
            idx_x_q  <= idx_g;
            pred_x_q <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (resolve) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule
